// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit that owns HI/LO. It computes one shift-add or restoring-divide step per cycle, W steps per operation.
// Optional macro MDU_DIVZERO_EN adds a single-cycle divide-by-zero path and a sticky div0 output.
module mdu_iter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [W-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
`ifdef MDU_DIVZERO_EN
    ,
    output logic         div0
`endif
);
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned AW = 2 * W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    op_q;
    logic          sign_a_q;
    logic          sign_b_q;
    logic [W-1:0]  opb_q;
    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic [W-1:0]  hi_q;
    logic [W-1:0]  lo_q;
    logic [W-1:0]  hi_d;
    logic [W-1:0]  lo_d;
    logic          busy_q;
    logic          done_q;
`ifdef MDU_DIVZERO_EN
    logic          dz_q;
    logic          div0_q;
`endif

    logic          sa_in;
    logic          sb_in;
    logic [W-1:0]  mag_a;
    logic [W-1:0]  mag_b;
    logic [W:0]    mul_sum;
    logic [W:0]    div_diff;
    logic [AW-1:0] prod;
    logic          neg_res;
    logic          neg_rem;

    // Operand prep, one iteration step, and final sign correction
    always_comb begin
        sa_in    = ~op[0] & a[W-1];
        sb_in    = ~op[0] & b[W-1];
        mag_a    = sa_in ? (~a + W'(1)) : a;
        mag_b    = sb_in ? (~b + W'(1)) : b;

        // acc = {partial product | remainder, multiplier | dividend}
        mul_sum  = {1'b0, acc_q[AW-1:W]} + {1'b0, opb_q & {W{acc_q[0]}}};
        div_diff = acc_q[AW-1:W-1] - {1'b0, opb_q};
        if (op_q[1]) begin
            acc_d = div_diff[W] ? {acc_q[AW-2:0], 1'b0}
                                : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
            acc_d = {mul_sum, acc_q[W-1:1]};
        end

        neg_res = ~op_q[0] & (sign_a_q ^ sign_b_q);
        neg_rem = ~op_q[0] & sign_a_q;
        prod    = neg_res ? (~acc_q + AW'(1)) : acc_q;
        if (op_q[1]) begin
            lo_d = neg_res ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
            hi_d = neg_rem ? (~acc_q[AW-1:W] + W'(1)) : acc_q[AW-1:W];
        end else begin
            hi_d = prod[AW-1:W];
            lo_d = prod[W-1:0];
        end
    end

    // Control FSM and architectural HI/LO state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MDU_DIVZERO_EN
            dz_q     <= 1'b0;
            div0_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        sign_a_q <= sa_in;
                        sign_b_q <= sb_in;
                        opb_q    <= mag_b;
                        acc_q    <= {W'(0), mag_a};
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
`ifdef MDU_DIVZERO_EN
                        div0_q   <= 1'b0;
                        if (op[1] && (b == '0)) begin
                            dz_q    <= 1'b1;
                            acc_q   <= {W'(0), a};
                            state_q <= S_FIX;
                        end else begin
                            dz_q    <= 1'b0;
                            state_q <= S_RUN;
                        end
`else
                        state_q  <= S_RUN;
`endif
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= CW'(cnt_q + 1'b1);
                    if (cnt_q == CW'(W - 1)) state_q <= S_FIX;
                end
                S_FIX: begin
`ifdef MDU_DIVZERO_EN
                    if (dz_q) begin
                        hi_q   <= acc_q[W-1:0];
                        lo_q   <= '1;
                        div0_q <= 1'b1;
                    end else begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                    end
`else
                    hi_q <= hi_d;
                    lo_q <= lo_d;
`endif
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MDU_DIVZERO_EN
    assign div0 = div0_q;
`endif

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter. A driver pushes the expected results, and a monitor checks each done pulse against them.
// Expected values come from plain 64-bit arithmetic. The bench honours MDU_DIVZERO_EN.
module tb_mdu_iter;
    localparam int unsigned W = 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_DIVZERO_EN
    logic        div0;
`endif

    int   n_pass = 0;
    int   n_tot = 0;
    int   cyc = 0;
    exp_t sb[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mdu_iter #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MDU_DIVZERO_EN
        , .div0(div0)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s act=%h req=%h", nm, act, req);
    endtask

    // Reference results from the architectural definition of each op
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        longint sx, sy, q, r;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.dz = 1'b0;
        e.lat = 33;
        e.t = 0;
        e.hi = '0;
        e.lo = '0;
        if (o[1] && y == 32'd0) begin
`ifdef MDU_DIVZERO_EN
            e.hi = x; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.lat = 1;
`else
            e.hi = x;
            e.lo = (o == 2'b10 && x[31]) ? 32'd1 : 32'hFFFF_FFFF;
`endif
        end else begin
            case (o)
                2'b00: begin u = 64'(sx * sy); e.hi = u[63:32]; e.lo = u[31:0]; end
                2'b01: begin u = {32'd0, x} * {32'd0, y}; e.hi = u[63:32]; e.lo = u[31:0]; end
                2'b10: begin
                    q = sx / sy; r = sx % sy;
                    u = 64'(q); e.lo = u[31:0];
                    u = 64'(r); e.hi = u[31:0];
                end
                default: begin e.lo = x / y; e.hi = x % y; end
            endcase
        end
        return e;
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic lw, input logic [31:0] d, input bit push, output exp_t e);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; lo_we = lw; wdata = d;
        e = model(o, x, y);
        e.t = cyc + 1;
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        chk("launch_busy", 32'(busy), 32'd1);
        chk("launch_lo_hold", lo, model_lo);
`ifdef MDU_DIVZERO_EN
        chk("launch_div0_clr", 32'(div0), 32'd0);
`endif
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        launch(o, x, y, 1'b0, 32'd0, 1'b1, e);
        wait_idle();
        model_hi = e.hi;
        model_lo = e.lo;
    endtask

    task automatic mt(input logic wh, input logic wl, input logic [31:0] d);
        @(negedge clk);
        hi_we = wh; lo_we = wl; wdata = d;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        if (wh) model_hi = d;
        if (wl) model_lo = d;
        chk("mt_hi", hi, model_hi);
        chk("mt_lo", lo, model_lo);
        chk("mt_no_done", 32'(done), 32'd0);
        chk("mt_no_busy", 32'(busy), 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    int   busy_cnt = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin : mon
        exp_t me;
        if (prev_done) chk("done_one_cycle", 32'(done), 32'd0);
        if (done) begin
            n_tot++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_done act=done req=no_done hi=%h lo=%h", hi, lo);
            end else begin
                n_pass++;
                me = sb.pop_front();
                chk("res_hi", hi, me.hi);
                chk("res_lo", lo, me.lo);
                chk("res_latency", 32'(cyc - me.t), 32'(me.lat));
                chk("res_busy_cycles", 32'(busy_cnt), 32'(me.lat));
`ifdef MDU_DIVZERO_EN
                chk("res_div0", 32'(div0), 32'(me.dz));
`endif
            end
        end
        prev_done = done;
        busy_cnt = busy ? busy_cnt + 1 : 0;
    end

    initial begin : drv
        exp_t e;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
`ifdef MDU_DIVZERO_EN
        chk("rst_div0", 32'(div0), 32'd0);
`endif

        // Directed operations from the architectural corner cases
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op(2'b11, 32'd100, 32'd7);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b11, 32'h0000_0055, 32'd0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000);

        // Idle MTHI / MTLO
        mt(1'b1, 1'b0, 32'h1234_5678);
        mt(1'b0, 1'b1, 32'h0BAD_F00D);
        mt(1'b1, 1'b1, 32'hA5A5_5A5A);

        // Start and MTLO in the same cycle: only the result lands in LO
        launch(2'b11, 32'd1000, 32'd33, 1'b1, 32'hCAFE_F00D, 1'b1, e);
        wait_idle();
        model_hi = e.hi; model_lo = e.lo;

        // Start and MTHI are ignored while a MULTU runs
        launch(2'b01, 32'h0001_0003, 32'h0002_0005, 1'b0, 32'd0, 1'b1, e);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd2; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        chk("run_hi_hold", hi, model_hi);
        chk("run_busy", 32'(busy), 32'd1);
        wait_idle();
        model_hi = e.hi; model_lo = e.lo;

        // Reset mid-run aborts without a done pulse
        launch(2'b10, 32'h7FFF_0000, 32'd3, 1'b0, 32'd0, 1'b0, e);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_hi = '0; model_lo = '0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        repeat (40) @(negedge clk);
        chk("abort_no_done", 32'(done), 32'd0);
        chk("abort_hi_late", hi, 32'd0);

        // Randomised mix of operations and idle writes
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end else begin
                ro = 2'($urandom_range(0, 3));
                ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5000)) : $urandom;
                case ($urandom_range(0, 7))
                    0:       rb = 32'd0;
                    1, 2:    rb = 32'($urandom_range(1, 1000));
                    3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                    default: rb = $urandom;
                endcase
                run_op(ro, ra, rb);
            end
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
